// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master streaming a contiguous on-chip RAM word region out as
// an Avalon-ST packet. Outstanding reads are credit-limited against a small
// output FIFO so the RAM's fixed 1-cycle read latency never drops a word.
// Optional feature macro: READER_STALL_CNT_EN adds the stall_cycles output.
module onchip_mem_stream_reader #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 25000,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
`ifdef READER_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              src_eop
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    issued_cnt;
  logic [LEN_W-1:0]    beat_cnt;
  logic                rd_pending;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    occ;
  logic                pop;
  logic                credit_c;
  logic                drain_done_c;
  logic                issue_c, accept_c, done_d, err_d;

  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_writedata  = '0;
  assign mem_clken      = 1'b1;

  // Stream side is a direct view of the FIFO head plus the output beat counter
  assign src_valid = (occ != '0);
  assign src_data  = fifo_mem[rd_ptr];
  assign src_sop   = src_valid && (beat_cnt == '0);
  assign src_eop   = src_valid && (beat_cnt == LEN_W'(len_q - LEN_W'(1)));
  assign pop       = src_valid && src_ready;

  // Reads in the address register and in the RAM pipeline both hold a FIFO slot
  assign credit_c = (32'(occ) + 32'(rd_pending) + 32'(mem_chipselect)) < FIFO_DEPTH;

  // Last word is leaving (or has left) and nothing is still in flight
  assign drain_done_c = !mem_chipselect && !rd_pending &&
                        ((occ == '0) || ((occ == CNT_W'(1)) && pop));

  // Next-state and command decode
  always_comb begin
    next_state = state;
    issue_c    = 1'b0;
    accept_c   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else if (32'(base_addr) >= DEPTH_WORDS) begin
            err_d = 1'b1;
          end else begin
            accept_c   = 1'b1;
            next_state = RUN;
          end
        end
      end
      RUN: begin
        if (credit_c) begin
          issue_c = 1'b1;
          if (LEN_W'(issued_cnt + LEN_W'(1)) == len_q) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done_c) begin
          done_d     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control state, RAM issue pipeline and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_address    <= '0;
      rd_pending     <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      issued_cnt     <= '0;
      beat_cnt       <= '0;
    end else begin
      state          <= next_state;
      busy           <= (next_state != IDLE);
      done           <= done_d;
      err            <= err_d;
      mem_chipselect <= issue_c;
      rd_pending     <= mem_chipselect;
      if (issue_c) begin
        mem_address <= addr_q;
        addr_q      <= (addr_q == ADDR_W'(DEPTH_WORDS - 1)) ? '0 : ADDR_W'(addr_q + ADDR_W'(1));
        issued_cnt  <= LEN_W'(issued_cnt + LEN_W'(1));
      end
      if (pop) beat_cnt <= LEN_W'(beat_cnt + LEN_W'(1));
      if (accept_c) begin
        addr_q     <= base_addr;
        len_q      <= length;
        issued_cnt <= '0;
        beat_cnt   <= '0;
      end
    end
  end

  // Output FIFO: written one cycle after each issue, read on each accepted beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (rd_pending) begin
        fifo_mem[wr_ptr] <= mem_readdata;
        wr_ptr           <= PTR_W'(wr_ptr + PTR_W'(1));
      end
      if (pop) rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      case ({rd_pending, pop})
        2'b10:   occ <= CNT_W'(occ + CNT_W'(1));
        2'b01:   occ <= CNT_W'(occ - CNT_W'(1));
        default: occ <= occ;
      endcase
    end
  end

`ifdef READER_STALL_CNT_EN
  // Saturating count of cycles where a valid beat is held off by the sink
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (accept_c) begin
      stall_cycles <= '0;
    end else if (src_valid && !src_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
